// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle for the sequential binary-to-BCD converter.
// master = requester / display side, slave = converter.
interface bin2bcd_seq_if #(
   parameter int W = 8,
   parameter int D = 3
);
   logic           start;
   logic [W-1:0]   bin;
   logic           busy;
   logic           done;
   logic [4*D-1:0] bcd;
   logic           overflow;
   logic [D-1:0]   blank;

   modport master (output start, bin, input busy, done, bcd, overflow, blank);
   modport slave  (input start, bin, output busy, done, bcd, overflow, blank);
endinterface

// File: rtl/bin2bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional leading-zero mask enabled by defining BIN2BCD_BLANK_EN.

// One decimal digit's add-3 correction.
module bin2bcd_seq_dig (
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = (d >= 4'd5 && d <= 4'd9) ? d + 4'd3 : d;
endmodule

module bin2bcd_seq #(
   parameter int W = 8,
   parameter int D = 3
) (
   input  logic         clk,
   input  logic         rst,
   bin2bcd_seq_if.slave io
);
   localparam int            CW   = $clog2(W + 1);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t         state;
   logic [W-1:0]   sr;
   logic [4*D-1:0] sc;
   logic [CW-1:0]  cnt;
   logic           ovf;

   logic [4*D-1:0] cor;
   logic [4*D-1:0] sc_nxt;
   logic [W-1:0]   sr_nxt;
   logic           ovf_nxt;

   genvar k;
   generate
      for (k = 0; k < D; k++) begin : g_dig
         bin2bcd_seq_dig u_dig (.d(sc[4*k +: 4]), .q(cor[4*k +: 4]));
      end
   endgenerate

   // A set MSB in the corrected top digit is the carry the shift drops.
   assign {sc_nxt, sr_nxt} = {cor, sr} << 1;
   assign ovf_nxt          = ovf | cor[4*D-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sr          <= '0;
         sc          <= '0;
         cnt         <= '0;
         ovf         <= 1'b0;
         io.busy     <= 1'b0;
         io.done     <= 1'b0;
         io.bcd      <= '0;
         io.overflow <= 1'b0;
      end else begin
         io.done <= 1'b0;
         case (state)
            IDLE: if (io.start) begin
               sr      <= io.bin;
               sc      <= '0;
               cnt     <= '0;
               ovf     <= 1'b0;
               io.busy <= 1'b1;
               state   <= SHIFT;
            end
            SHIFT: begin
               sr  <= sr_nxt;
               sc  <= sc_nxt;
               ovf <= ovf_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  io.bcd      <= sc_nxt;
                  io.overflow <= ovf_nxt;
                  io.done     <= 1'b1;
                  io.busy     <= 1'b0;
                  state       <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef BIN2BCD_BLANK_EN
   // Digit 0 is never blanked so a zero value still shows one "0".
   localparam logic [D-1:0] BLANK_RST = {D{1'b1}} << 1;

   logic [D-1:0] blank_q;
   logic [D-1:0] blank_nxt;
   logic         upper_zero;

   always_comb begin
      blank_nxt  = '0;
      upper_zero = 1'b1;
      for (int i = D - 1; i >= 1; i--) begin
         upper_zero   = upper_zero & (sc_nxt[4*i +: 4] == 4'd0);
         blank_nxt[i] = upper_zero;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                              blank_q <= BLANK_RST;
      else if (state == SHIFT && cnt == LAST) blank_q <= blank_nxt;
   end

   assign io.blank = blank_q;
`else
   assign io.blank = '0;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed-vector bench for bin2bcd_seq: a W=8/D=3 and a W=8/D=2 instance.
module tb_bin2bcd_seq;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

`ifdef BIN2BCD_BLANK_EN
   localparam bit BEN = 1'b1;
`else
   localparam bit BEN = 1'b0;
`endif

   bin2bcd_seq_if #(.W(8), .D(3)) io3 ();
   bin2bcd_seq_if #(.W(8), .D(2)) io2 ();

   bin2bcd_seq #(.W(8), .D(3)) dut3 (.clk(clk), .rst(rst), .io(io3));
   bin2bcd_seq #(.W(8), .D(2)) dut2 (.clk(clk), .rst(rst), .io(io2));

   int nvec = 0;
   int nerr = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a one-cycle start, then count cycles (and busy cycles) until done.
   task automatic conv(input bit sel2, input logic [7:0] v, output int lat, output int bcyc);
      if (sel2) begin io2.bin = v; io2.start = 1'b1; end
      else      begin io3.bin = v; io3.start = 1'b1; end
      tick();
      io2.start = 1'b0; io3.start = 1'b0;
      lat = 0; bcyc = 0;
      while (!(sel2 ? io2.done : io3.done) && lat < 40) begin
         if (sel2 ? io2.busy : io3.busy) bcyc++;
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; io3.start = 1'b0; io3.bin = '0; io2.start = 1'b0; io2.bin = '0;
      tick(); tick();
      rst = 1'b0;
      nvec++; if (io3.busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %0b want 0", io3.busy); end
      nvec++; if (io3.done !== 1'b0) begin nerr++; $display("FAIL rst_done: got %0b want 0", io3.done); end
      nvec++; if (io3.bcd !== 12'h000) begin nerr++; $display("FAIL rst_bcd: got %0h want 0", io3.bcd); end
      nvec++; if (io3.overflow !== 1'b0) begin nerr++; $display("FAIL rst_ovf: got %0b want 0", io3.overflow); end
      nvec++; if (io3.blank !== (BEN ? 3'b110 : 3'b000)) begin nerr++; $display("FAIL rst_blank3: got %b want %b", io3.blank, BEN ? 3'b110 : 3'b000); end
      nvec++; if (io2.blank !== (BEN ? 2'b10 : 2'b00)) begin nerr++; $display("FAIL rst_blank2: got %b want %b", io2.blank, BEN ? 2'b10 : 2'b00); end
   endtask

   task automatic test_255();
      int lat, bcyc;
      conv(1'b0, 8'd255, lat, bcyc);
      nvec++; if (lat !== 8) begin nerr++; $display("FAIL c255_lat: got %0d want 8", lat); end
      nvec++; if (bcyc !== 8) begin nerr++; $display("FAIL c255_busy: got %0d want 8", bcyc); end
      nvec++; if (io3.bcd !== 12'h255) begin nerr++; $display("FAIL c255_bcd: got %0h want 255", io3.bcd); end
      nvec++; if (io3.overflow !== 1'b0) begin nerr++; $display("FAIL c255_ovf: got %0b want 0", io3.overflow); end
      nvec++; if (io3.blank !== 3'b000) begin nerr++; $display("FAIL c255_blank: got %b want 000", io3.blank); end
      tick();
      nvec++; if (io3.done !== 1'b0) begin nerr++; $display("FAIL c255_pulse: got %0b want 0", io3.done); end
      nvec++; if (io3.bcd !== 12'h255) begin nerr++; $display("FAIL c255_hold: got %0h want 255", io3.bcd); end
   endtask

   task automatic test_zero();
      int lat, bcyc;
      conv(1'b0, 8'd0, lat, bcyc);
      nvec++; if (lat !== 8) begin nerr++; $display("FAIL c0_lat: got %0d want 8", lat); end
      nvec++; if (io3.bcd !== 12'h000) begin nerr++; $display("FAIL c0_bcd: got %0h want 000", io3.bcd); end
      nvec++; if (io3.blank !== (BEN ? 3'b110 : 3'b000)) begin nerr++; $display("FAIL c0_blank: got %b want %b", io3.blank, BEN ? 3'b110 : 3'b000); end
   endtask

   task automatic test_back_to_back();
      int lat, bcyc;
      conv(1'b0, 8'd9, lat, bcyc);
      nvec++; if (io3.bcd !== 12'h009) begin nerr++; $display("FAIL b2b_bcd9: got %0h want 009", io3.bcd); end
      nvec++; if (io3.blank !== (BEN ? 3'b110 : 3'b000)) begin nerr++; $display("FAIL b2b_blank9: got %b want %b", io3.blank, BEN ? 3'b110 : 3'b000); end
      // start held during the done cycle must be accepted
      io3.bin = 8'd10; io3.start = 1'b1;
      tick();
      io3.start = 1'b0;
      nvec++; if (io3.busy !== 1'b1) begin nerr++; $display("FAIL b2b_accept: got %0b want 1", io3.busy); end
      nvec++; if (io3.done !== 1'b0) begin nerr++; $display("FAIL b2b_pulse: got %0b want 0", io3.done); end
      lat = 0;
      while (!io3.done && lat < 40) begin tick(); lat++; end
      nvec++; if (lat !== 8) begin nerr++; $display("FAIL b2b_lat: got %0d want 8", lat); end
      nvec++; if (io3.bcd !== 12'h010) begin nerr++; $display("FAIL b2b_bcd10: got %0h want 010", io3.bcd); end
      nvec++; if (io3.blank !== (BEN ? 3'b100 : 3'b000)) begin nerr++; $display("FAIL b2b_blank10: got %b want %b", io3.blank, BEN ? 3'b100 : 3'b000); end
   endtask

   task automatic test_ignore_busy_start();
      int lat, ndone;
      io3.bin = 8'd200; io3.start = 1'b1;
      tick();
      io3.start = 1'b0;
      tick(); tick();
      io3.bin = 8'd7; io3.start = 1'b1;
      tick();
      io3.start = 1'b0;
      lat = 3;
      while (!io3.done && lat < 40) begin tick(); lat++; end
      nvec++; if (lat !== 8) begin nerr++; $display("FAIL ign_lat: got %0d want 8", lat); end
      nvec++; if (io3.bcd !== 12'h200) begin nerr++; $display("FAIL ign_bcd: got %0h want 200", io3.bcd); end
      ndone = 0;
      for (int i = 0; i < 12; i++) begin tick(); if (io3.done) ndone++; end
      nvec++; if (ndone !== 0) begin nerr++; $display("FAIL ign_extra_done: got %0d want 0", ndone); end
      nvec++; if (io3.busy !== 1'b0) begin nerr++; $display("FAIL ign_busy: got %0b want 0", io3.busy); end
   endtask

   task automatic test_reset_mid();
      int ndone;
      io3.bin = 8'd123; io3.start = 1'b1;
      tick();
      io3.start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      nvec++; if (io3.busy !== 1'b0) begin nerr++; $display("FAIL rmid_busy: got %0b want 0", io3.busy); end
      nvec++; if (io3.done !== 1'b0) begin nerr++; $display("FAIL rmid_done: got %0b want 0", io3.done); end
      nvec++; if (io3.bcd !== 12'h000) begin nerr++; $display("FAIL rmid_bcd: got %0h want 000", io3.bcd); end
      nvec++; if (io3.blank !== (BEN ? 3'b110 : 3'b000)) begin nerr++; $display("FAIL rmid_blank: got %b want %b", io3.blank, BEN ? 3'b110 : 3'b000); end
      ndone = 0;
      for (int i = 0; i < 12; i++) begin tick(); if (io3.done) ndone++; end
      nvec++; if (ndone !== 0) begin nerr++; $display("FAIL rmid_no_done: got %0d want 0", ndone); end
      // reset and start together: start is dropped
      rst = 1'b1; io3.bin = 8'd55; io3.start = 1'b1;
      tick();
      rst = 1'b0; io3.start = 1'b0;
      tick();
      nvec++; if (io3.busy !== 1'b0) begin nerr++; $display("FAIL rst_start_busy: got %0b want 0", io3.busy); end
   endtask

   task automatic test_overflow_d2();
      int lat, bcyc;
      conv(1'b1, 8'd100, lat, bcyc);
      nvec++; if (lat !== 8) begin nerr++; $display("FAIL d2_lat: got %0d want 8", lat); end
      nvec++; if (io2.overflow !== 1'b1) begin nerr++; $display("FAIL d2_ovf100: got %0b want 1", io2.overflow); end
      nvec++; if (io2.bcd !== 8'h00) begin nerr++; $display("FAIL d2_bcd100: got %0h want 00", io2.bcd); end
      nvec++; if (io2.blank !== (BEN ? 2'b10 : 2'b00)) begin nerr++; $display("FAIL d2_blank100: got %b want %b", io2.blank, BEN ? 2'b10 : 2'b00); end
      conv(1'b1, 8'd99, lat, bcyc);
      nvec++; if (io2.overflow !== 1'b0) begin nerr++; $display("FAIL d2_ovf99: got %0b want 0", io2.overflow); end
      nvec++; if (io2.bcd !== 8'h99) begin nerr++; $display("FAIL d2_bcd99: got %0h want 99", io2.bcd); end
      nvec++; if (io2.blank !== 2'b00) begin nerr++; $display("FAIL d2_blank99: got %b want 00", io2.blank); end
   endtask

   initial begin
      test_reset();
      test_255();
      test_zero();
      test_back_to_back();
      test_ignore_busy_start();
      test_reset_mid();
      test_overflow_d2();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
